qmult_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational sign-magnitude Q-format multiplier used across the Codec2 encoder datapath.
- Adds a valid/ready handshake, configurable latency, overflow detection with saturation, and canonical zero.
- Sits between the LPC/pitch arithmetic FSMs and their result registers, so long multiplies no longer set the critical path.

---
 rtl/qmult_pipe.sv | 127 ++++++++++++
 tb/tb_qmult_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmult_pipe.sv
// ============================================================================
//  Module   : qmult_pipe
//  Purpose  : Pipelined sign-magnitude Q-format multiplier with valid/ready
//             handshake, saturation on overflow and canonical zero.
//             The multiply is registered in the first stage. Saturation,
//             optional rounding and sign handling are registered in the last
//             stage. Any stages in between are plain delay.
//  Options  : QMULT_PIPE_ROUND_EN - round-half-up on the truncated magnitude
//             (default: truncation only, no rounding adder)
//  Revision : 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

module qmult_pipe #(
    parameter int N      = 32,  // word width including sign bit
    parameter int Q      = 15,  // fractional bits, 1..N-2
    parameter int STAGES = 2    // accept-to-o_valid latency, 1..4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_ovr
);

    localparam int c_prod_w = 2 * N - 2;

    logic [STAGES-1:0]   r_vld;
    logic [STAGES:0]     w_vld_in;
    logic                w_adv;
    logic [c_prod_w-1:0] w_prod;
    logic                w_sign;
    logic [N-1:0]        r_result;
    logic                r_ovr;

    // Post-processing: returns {ovr, sign, magnitude} for a raw magnitude product.
    function automatic logic [N:0] post_proc(input logic [c_prod_w-1:0] p,
                                             input logic                s);
        logic         ovf;
        logic [N-2:0] mag;
`ifdef QMULT_PIPE_ROUND_EN
        logic [N-1:0] rnd;
        // Extra top bit catches the carry-out of the rounding increment.
        rnd = {1'b0, p[N-2+Q:Q]} + {{(N-1){1'b0}}, p[Q-1]};
        ovf = (|p[c_prod_w-1:N-1+Q]) | rnd[N-1];
        mag = ovf ? '1 : rnd[N-2:0];
`else
        ovf = |p[c_prod_w-1:N-1+Q];
        mag = ovf ? '1 : p[N-2+Q:Q];
`endif
        // A zero magnitude always leaves with a positive sign.
        return {ovf, s & (mag != '0), mag};
    endfunction

    // Whole pipeline moves together whenever the output slot is free or draining.
    assign w_adv   = !r_vld[STAGES-1] || i_ready;
    assign o_ready = w_adv;
    assign o_valid = r_vld[STAGES-1];
    assign o_result = r_result;
    assign o_ovr    = r_ovr;

    assign w_prod   = c_prod_w'(i_multiplicand[N-2:0]) * c_prod_w'(i_multiplier[N-2:0]);
    assign w_sign   = i_multiplicand[N-1] ^ i_multiplier[N-1];
    assign w_vld_in = {r_vld, i_valid};

    // Valid shift chain; bubbles travel through like any other slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= w_vld_in[STAGES-1:0];
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            // Multiply and post-process land in the one and only register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_result <= '0;
                    r_ovr    <= 1'b0;
                end else if (w_adv) begin
                    {r_ovr, r_result} <= post_proc(w_prod, w_sign);
                end
            end
        end else begin : g_multi
            logic [c_prod_w-1:0] r_prod [STAGES-1];
            logic                r_sign [STAGES-1];

            // First stage captures the raw magnitude product and result sign.
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_prod[0] <= w_prod;
                    r_sign[0] <= w_sign;
                end
            end

            for (genvar i = 1; i < STAGES - 1; i++) begin : g_dly
                // Pure delay stage.
                always_ff @(posedge clk) begin
                    if (w_adv) begin
                        r_prod[i] <= r_prod[i-1];
                        r_sign[i] <= r_sign[i-1];
                    end
                end
            end

            // Last stage saturates, optionally rounds, and fixes the sign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_result <= '0;
                    r_ovr    <= 1'b0;
                end else if (w_adv) begin
                    {r_ovr, r_result} <= post_proc(r_prod[STAGES-2], r_sign[STAGES-2]);
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_qmult_pipe.sv
// ============================================================================
//  Module   : tb_qmult_pipe
//  Purpose  : Self-checking bench for qmult_pipe. Four instances with
//             STAGES = 1..4 share the same stimulus; each has its own
//             scoreboard fed by an arithmetic reference model.
//  Options  : QMULT_PIPE_ROUND_EN selects the rounding reference model
//  Revision : 1.0 - initial bench
// ============================================================================
`default_nettype none

module tb_qmult_pipe;

    localparam int N = 32;
    localparam int Q = 15;

    typedef struct packed {
        logic [32:0] e;    // {ovr, result}
        logic [31:0] t;    // cycle index at acceptance
        logic        lc;   // latency is checkable for this entry
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ordy;
    logic [3:0]   ov;
    logic [3:0]   oovr;
    logic [N-1:0] ores [4];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;
    int outstanding [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: exact integer product, scaled down, saturated, signed.
    function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned prod;
        longint unsigned mag;
        logic            ovr;
        logic            sgn;
        ma   = longint'(x[30:0]);
        mb   = longint'(y[30:0]);
        prod = ma * mb;
        mag  = prod >> Q;
`ifdef QMULT_PIPE_ROUND_EN
        mag  = mag + ((prod >> (Q - 1)) & 64'd1);
`endif
        ovr = (mag > 64'h7FFF_FFFF);
        if (ovr) mag = 64'h7FFF_FFFF;
        sgn = (x[31] ^ y[31]) && (mag != 0);
        return {ovr, sgn, mag[30:0]};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        v = $urandom;
        v[30:0] = v[30:0] >> $urandom_range(0, 30);
        if ($urandom_range(0, 15) == 0) v[30:0] = '0;
        return v;
    endfunction

    for (genvar d = 0; d < 4; d++) begin : g_dut
        ent_t        q [$];
        ent_t        ent;
        logic        hold = 1'b0;
        logic [32:0] held;

        qmult_pipe #(.N(N), .Q(Q), .STAGES(d + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .i_valid        (i_valid),
            .o_ready        (ordy[d]),
            .i_multiplicand (a),
            .i_multiplier   (b),
            .o_valid        (ov[d]),
            .i_ready        (i_ready),
            .o_result       (ores[d]),
            .o_ovr          (oovr[d])
        );

        // Scoreboard for this instance, sampled mid-cycle.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                hold = 1'b0;
                outstanding[d] = 0;
            end else begin
                chk($sformatf("ready_s%0d", d + 1), {63'd0, ordy[d]}, {63'd0, (!ov[d] || i_ready)});
                if (hold) begin
                    chk($sformatf("hold_vld_s%0d", d + 1), {63'd0, ov[d]}, 64'd1);
                    chk($sformatf("hold_res_s%0d", d + 1), {31'd0, oovr[d], ores[d]}, {31'd0, held});
                end
                if (ov[d]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("spurious_vld_s%0d", d + 1), {63'd0, ov[d]}, 64'd0);
                    end else if (i_ready) begin
                        ent = q.pop_front();
                        outstanding[d] = outstanding[d] - 1;
                        chk($sformatf("res_s%0d", d + 1), {31'd0, oovr[d], ores[d]}, {31'd0, ent.e});
                        if (ent.lc && lat_chk)
                            chk($sformatf("lat_s%0d", d + 1), 64'(cyc - int'(ent.t)), 64'(d + 1));
                    end
                end
                hold = ov[d] && !i_ready;
                held = {oovr[d], ores[d]};
                if (i_valid && ordy[d]) begin
                    q.push_back('{e: ref_mul(a, b), t: 32'(cyc), lc: lat_chk});
                    outstanding[d] = outstanding[d] + 1;
                end
            end
        end
    end

    // One op with i_ready high; each instance must show it exactly once, STAGES-1 edges later.
    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic [32:0] exp);
        a = x;
        b = y;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("dir_vld_s%0d_j%0d", d + 1, j), {63'd0, ov[d]}, {63'd0, (j == d)});
                if (j == d)
                    chk($sformatf("dir_res_s%0d_%h", d + 1, x), {31'd0, oovr[d], ores[d]}, {31'd0, exp});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("drain_s%0d", d + 1), 64'(outstanding[d]), 64'd0);
    endtask

    initial begin
        int k;
        int n;
        bit acc;
        logic [31:0] bp_a [4];
        logic [31:0] bp_b [4];

        rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_vld", {63'd0, ov[d]}, 64'd0);
            chk("rst_rdy", {63'd0, ordy[d]}, 64'd1);
            chk("rst_res", {31'd0, oovr[d], ores[d]}, 64'd0);
        end
        rst = 1'b0;
        lat_chk = 1'b1;

        // Directed arithmetic cases.
        directed(32'h0000_C000, 32'h0001_0000, {1'b0, 32'h0001_8000});
        directed(32'h8000_C000, 32'h0001_0000, {1'b0, 32'h8001_8000});
        directed(32'h7FFF_FFFF, 32'h0001_0000, {1'b1, 32'h7FFF_FFFF});
        directed(32'hFFFF_FFFF, 32'h0001_0000, {1'b1, 32'hFFFF_FFFF});
`ifdef QMULT_PIPE_ROUND_EN
        directed(32'h8000_0001, 32'h0000_4000, {1'b0, 32'h8000_0001});
`else
        directed(32'h8000_0001, 32'h0000_4000, {1'b0, 32'h0000_0000});
`endif
        directed(32'h0000_0001, 32'h0000_2000, {1'b0, 32'h0000_0000});
        directed(32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000});

        // Backpressure: four pairs into the STAGES=3 instance, i_ready low for cycles 2..6.
        lat_chk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = rnd_opnd();
            bp_b[i] = rnd_opnd();
        end
        k = 0;
        n = 0;
        while (n < 20) begin
            i_ready = !(n >= 2 && n < 7);
            if (k < 4) begin
                i_valid = 1'b1;
                a = bp_a[k];
                b = bp_b[k];
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            acc = i_valid && ordy[2];
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        chk("bp_accepted", 64'(k), 64'd4);
        drain();
        lat_chk = 1'b1;

        // Reset mid-flight: three ops in, reset, then a fresh op.
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            a = rnd_opnd();
            b = rnd_opnd();
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            chk("midrst_vld", {63'd0, ov[d]}, 64'd0);
            chk("midrst_rdy", {63'd0, ordy[d]}, 64'd1);
        end
        directed(32'h0000_C000, 32'h0001_0000, {1'b0, 32'h0001_8000});

        // Full rate with downstream always ready: latency is exact.
        repeat (300) begin
            i_valid = ($urandom_range(0, 3) != 0);
            a = rnd_opnd();
            b = rnd_opnd();
            @(posedge clk);
            #1;
        end
        drain();

        // Random downstream backpressure.
        lat_chk = 1'b0;
        repeat (600) begin
            i_ready = ($urandom_range(0, 2) != 0);
            i_valid = ($urandom_range(0, 3) != 0);
            a = rnd_opnd();
            b = rnd_opnd();
            @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
